result_display: RTL and testbench
=================================

// Module: result_display
// PURPOSE
// Consumer end of the processor's 32-bit `out` result port: watches the word, declares it settled once it holds
// steady for STABLE_CYCLES clocks, latches it and shows it as hex on a multiplexed, active-low 7-segment bank.
// Sits beside `microarchitecture` in the board top; `sw` drives the core, this block reads `out` back to the user.
// PARAMETERS
// DIGITS        8     number of hex digits scanned (1..8); digit i shows nibble i of the displayed word
// REFRESH_DIV   1000  clocks each digit stays lit before the scan advances (>=2)
// STABLE_CYCLES 16    consecutive unchanged clocks before out_word counts as settled (>=1)
// BLANK_LZ      1     1: blank leading-zero digits (digit 0 always lit); 0: light every digit
// PORTS
// clk           in   1       system clock, all logic on rising edge
// rst           in   1       synchronous reset, ACTIVE-LOW (rst==0 at a rising edge resets)
// out_word      in   32      processor result word (`out`)
// freeze        in   1       1: hold displayed word; stability tracking continues
// seg           out  7       segments {g,f,e,d,c,b,a}, active-low, registered
// an            out  DIGITS  digit enables, active-low one-hot, registered
// dp            out  1       decimal point, active-low; lit only on digit 0 while result_valid==0
// result_valid  out  1       high while out_word has held for STABLE_CYCLES clocks
// changed       out  1       one-clock pulse in the cycle after out_word differed from the previous sample
// BEHAVIOUR
// Reset (rst==0 at an edge): prev=0, stab_cnt=0, disp_word=0, div=0, idx=0, changed=0, seg=7'h7F, an=all 1, dp=1.
// Stability tracker, every edge: prev<=out_word.
// - out_word!=prev: stab_cnt<=0, changed<=1. Otherwise changed<=0 and stab_cnt increments.
// - stab_cnt saturates at STABLE_CYCLES and never wraps.
// - result_valid = (stab_cnt==STABLE_CYCLES), combinational from the register.
// - A word first sampled at edge E (differing from prev) gives result_valid=1 after edge E+STABLE_CYCLES.
// Display latch: disp_word<=out_word on the edge where stab_cnt goes STABLE_CYCLES-1 -> STABLE_CYCLES, if freeze==0.
// - It is a single-edge load: dropping freeze later does not reload until the next settle event.
// - A change on the settle edge itself blocks the load, because that edge takes the mismatch branch.
// Scan counter:
// - div counts 0..REFRESH_DIV-1. At wrap, div<=0 and idx<=(idx==DIGITS-1)?0:idx+1.
// - idx is never outside 0..DIGITS-1.
// Output stage: registered, so seg/an/dp reflect the idx/disp_word values from the previous clock.
// - an = ~(1<<idx). If BLANK_LZ, idx>0 and every nibble idx..DIGITS-1 of disp_word is 0, then an = all 1 (blanked).
// - seg = hex decode of disp_word[4*idx+:4], active-low: 0=7'b1000000, 1=7'b1111001, 8=7'b0000000, D=7'b0100001, F=7'b0001110.
// - disp_word=0 shows a single "0" on digit 0.
// Reset mid-scan or mid-settle discards all progress; the first lit output is digit 0, the cycle after rst returns to 1.
// freeze does not affect scan, result_valid or changed.
// TESTING (bench params: DIGITS=8, REFRESH_DIV=4, STABLE_CYCLES=4, BLANK_LZ=1)
// 1) rst=0 for 5 clk, out_word=13 -> seg=7F, an=FF, dp=1, result_valid=0 throughout.
// 2) rst->1, out_word=13 held -> changed pulses 1 clk; result_valid=1 four edges later; disp_word=13;
//    digit 0 shows seg=0100001 with an=FE; digits 1..7 are blanked (an=FF) during their slots.
// 3) out_word 13->0x1234ABCD after settle -> result_valid drops the next cycle; changed pulses;
//    4 stable edges later all 8 digits are lit and digit 7 shows "1" (seg=1111001).
// 4) freeze=1, out_word changes and settles -> result_valid=1 but disp_word unchanged; freeze=0 -> still unchanged.
// 5) Scan wrap -> idx sequence 0..7,0 with each digit held exactly 4 clk; an walks FE,FD,...,7F,FE.
// 6) rst=0 for 1 clk while idx=5 and stab_cnt=2 -> all outputs return to reset values;
//    with out_word=13 held, rescan starts at digit 0 and result_valid re-arms after the full count.

Source files
------------

// File: rtl/result_display.sv
// rtl/result_display.sv - settle-detect latch and multiplexed active-low hex display of a 32-bit result word
//
// Watches out_word, declares it settled after STABLE_CYCLES unchanged clocks,
// latches it (unless frozen) and scans it as hex over DIGITS 7-segment digits.
//
// Ports:
//   clk          in   1       rising-edge clock
//   rst          in   1       synchronous reset, active-low
//   out_word     in   32      processor result word
//   freeze       in   1       1: hold displayed word
//   seg          out  7       {g,f,e,d,c,b,a}, active-low, registered
//   an           out  DIGITS  digit enables, active-low one-hot, registered
//   dp           out  1       decimal point, active-low, lit on digit 0 while unsettled
//   result_valid out  1       out_word has held for STABLE_CYCLES clocks
//   changed      out  1       pulse the cycle after out_word differed from its previous sample
module result_display #(
   parameter int DIGITS        = 8,
   parameter int REFRESH_DIV   = 1000,
   parameter int STABLE_CYCLES = 16,
   parameter bit BLANK_LZ      = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       out_word,
   input  logic              freeze,
   output logic [6:0]        seg,
   output logic [DIGITS-1:0] an,
   output logic              dp,
   output logic              result_valid,
   output logic              changed
);

   localparam int SW = $clog2(STABLE_CYCLES + 1);
   localparam int DW = $clog2(REFRESH_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [SW-1:0]     SAT      = SW'(STABLE_CYCLES);
   localparam logic [DW-1:0]     DIV_LAST = DW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
   localparam logic [DIGITS-1:0] AN_ONE   = DIGITS'(1);
   // Only nibbles that have a digit take part in leading-zero blanking.
   localparam logic [31:0]       NIB_MASK = (DIGITS >= 8) ? 32'hFFFF_FFFF
                                          : ((32'h1 << (4 * DIGITS)) - 32'h1);

   logic [31:0]   prev;
   logic [SW-1:0] stab_cnt;
   logic [31:0]   disp_word;
   logic [DW-1:0] div;
   logic [IW-1:0] idx;

   logic [31:0]   shifted;
   logic [3:0]    nib;
   logic          blank;

   assign result_valid = (stab_cnt == SAT);

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

   // Stability tracker and display latch.
   always_ff @(posedge clk) begin
      if (!rst) begin
         prev      <= '0;
         stab_cnt  <= '0;
         changed   <= 1'b0;
         disp_word <= '0;
      end else begin
         prev <= out_word;
         if (out_word != prev) begin
            stab_cnt <= '0;
            changed  <= 1'b1;
         end else begin
            changed <= 1'b0;
            if (stab_cnt != SAT)
               stab_cnt <= stab_cnt + 1'b1;
            // Load only on the settle edge itself; a later freeze drop does not reload.
            if (stab_cnt == SAT - 1'b1 && !freeze)
               disp_word <= out_word;
         end
      end
   end

   // Scan counter.
   always_ff @(posedge clk) begin
      if (!rst) begin
         div <= '0;
         idx <= '0;
      end else if (div == DIV_LAST) begin
         div <= '0;
         idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         div <= div + 1'b1;
      end
   end

   always_comb begin
      shifted = (disp_word & NIB_MASK) >> {idx, 2'b00};
      nib     = shifted[3:0];
      blank   = BLANK_LZ && (idx != '0) && (shifted == 32'h0);
   end

   // Output stage: reflects idx/disp_word/result_valid of the previous clock.
   always_ff @(posedge clk) begin
      if (!rst) begin
         seg <= 7'h7F;
         an  <= '1;
         dp  <= 1'b1;
      end else begin
         seg <= hex7(nib);
         an  <= blank ? '1 : ~(AN_ONE << idx);
         dp  <= !((idx == '0) && !result_valid);
      end
   end

endmodule

// File: tb/tb_result_display.sv
// tb/tb_result_display.sv - scoreboard bench for result_display with a cycle-level reference model
module tb_result_display;

   localparam int D = 8;
   localparam int R = 4;
   localparam int S = 4;

   logic        clk;
   logic        rst;
   logic [31:0] out_word;
   logic        freeze;
   logic [6:0]  seg;
   logic [D-1:0] an;
   logic        dp;
   logic        result_valid;
   logic        changed;

   result_display #(
      .DIGITS(D), .REFRESH_DIV(R), .STABLE_CYCLES(S), .BLANK_LZ(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .out_word(out_word), .freeze(freeze),
      .seg(seg), .an(an), .dp(dp), .result_valid(result_valid), .changed(changed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] seg;
      logic [7:0] an;
      logic       dp;
      logic       rv;
      logic       chg;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   logic [6:0] seg_tab [16];

   // Reference state: words as seen at edges, run length since last change,
   // displayed word and number of scanning edges since reset.
   logic [31:0] m_prev;
   logic [31:0] m_disp;
   int          m_run;
   int          m_n;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cycle %0d actual %h required %h", name, cyc, act, req);
      end
   endtask

   task automatic step(input logic r, input logic [31:0] w, input logic f);
      exp_t e;
      int   k;
      logic [31:0] hi;
      @(negedge clk);
      rst      = r;
      out_word = w;
      freeze   = f;
      if (!r) begin
         e.seg = 7'h7F; e.an = 8'hFF; e.dp = 1'b1; e.rv = 1'b0; e.chg = 1'b0;
         m_prev = 0; m_disp = 0; m_run = 0; m_n = 0;
      end else begin
         k     = (m_n / R) % D;
         hi    = m_disp >> (4 * k);
         e.seg = seg_tab[hi[3:0]];
         e.an  = (k > 0 && hi == 0) ? 8'hFF : ~(8'h01 << k);
         e.dp  = !(k == 0 && m_run < S);
         e.chg = (w != m_prev);
         if (w != m_prev) m_run = 0;
         else if (m_run < 1000) m_run++;
         if (w == m_prev && m_run == S && !f) m_disp = w;
         e.rv  = (m_run >= S);
         m_prev = w;
         m_n++;
      end
      q.push_back(e);
   endtask

   always begin
      exp_t e;
      @(posedge clk);
      #2;
      cyc++;
      if (q.size() > 0) begin
         e = q.pop_front();
         check("seg", {25'd0, seg}, {25'd0, e.seg});
         check("an", {24'd0, an}, {24'd0, e.an});
         check("dp", {31'd0, dp}, {31'd0, e.dp});
         check("result_valid", {31'd0, result_valid}, {31'd0, e.rv});
         check("changed", {31'd0, changed}, {31'd0, e.chg});
      end
   end

   initial begin
      logic [31:0] w;
      logic        f;
      logic        r;
      seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
      seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
      seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
      seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
      seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
      seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
      seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
      seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
      rst = 1'b0; out_word = 32'd13; freeze = 1'b0;

      // Reset, settle on 13, new wide word across a full scan, frozen settle.
      repeat (5)  step(1'b0, 32'd13, 1'b0);
      repeat (40) step(1'b1, 32'd13, 1'b0);
      repeat (40) step(1'b1, 32'h1234_ABCD, 1'b0);
      repeat (12) step(1'b1, 32'h0000_0F00, 1'b1);
      repeat (12) step(1'b1, 32'h0000_0F00, 1'b0);
      // Mid-scan reset: 22 edges since last reset puts idx at 5; change then 2 stable edges.
      step(1'b0, 32'h0000_0F00, 1'b0);
      repeat (19) step(1'b1, 32'h0000_0F00, 1'b0);
      repeat (3)  step(1'b1, 32'h0000_0042, 1'b0);
      step(1'b0, 32'd13, 1'b0);
      repeat (40) step(1'b1, 32'd13, 1'b0);

      // Randomized traffic with variable leading zeros, freeze toggles and sparse resets.
      w = 32'd13; f = 1'b0;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            w = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) w = w & 32'h0000_000F;
         end
         if ($urandom_range(0, 19) == 0) f = ~f;
         r = ($urandom_range(0, 99) != 0);
         step(r, w, f);
      end

      repeat (2) @(posedge clk);
      #5;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain actual %0d required 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
